// File: rtl/grev_arbiter_if.sv
// grev_arbiter_if: request/response bundle between two requesters, one consumer and grev_arbiter
// Signals:
//   req0_valid/req1_valid : requester has an operation pending
//   req0_ready/req1_ready : operation accepted this cycle
//   req0_rs1/req1_rs1     : 32-bit data operand
//   req0_rs2/req1_rs2     : 5-bit generalized-reverse control
//   rsp_valid             : result available
//   rsp_ready             : consumer accepts result
//   rsp_rd                : 32-bit result value
//   rsp_id                : index of the requester that issued the operation
// Modports: master = requester/consumer side, slave = arbiter side.
interface grev_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [31:0] req0_rs1;
  logic [31:0] req1_rs1;
  logic [4:0]  req0_rs2;
  logic [4:0]  req1_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd;
  logic        rsp_id;
  modport master (
    output req0_valid, req1_valid, req0_rs1, req1_rs1, req0_rs2, req1_rs2, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_rd, rsp_id
  );
  modport slave (
    input  req0_valid, req1_valid, req0_rs1, req1_rs1, req0_rs2, req1_rs2, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_rd, rsp_id
  );
endinterface

// File: rtl/grev_arbiter.sv
// grev_arbiter: two requesters share one iterative generalized-reverse unit (IDLE/BUSY/DONE)
// Parameters:
//   FAIR_RR : 1 = round-robin between contending requesters, 0 = req0 always wins
// Ports:
//   clock : sole clock, all state updates on posedge
//   reset : asynchronous active-high reset
//   bus   : grev_arbiter_if.slave (request handshakes, operands, response handshake)
// Macro GREV_STAGE_SKIP_EN: when defined, BUSY visits only stages whose rs2 bit is set,
//   giving latency 1+popcount(rs2); rs2 = 0 goes straight from IDLE to DONE.
//   When undefined, all five stages are walked and the response appears 6 cycles after accept.
module grev_arbiter #(
  parameter bit FAIR_RR = 1'b1
) (
  input logic clock,
  input logic reset,
  grev_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state, state_n;
  logic [31:0] data, data_n;
  logic [4:0]  ctl, ctl_n;
  logic [2:0]  cnt, cnt_n;
  logic        id, id_n;
  logic        last, last_n;
  logic        g1;
  logic        acc;
  logic [4:0]  rs2_sel;
  logic [31:0] stage_v;
  function automatic logic [31:0] grev_stage(input logic [31:0] x, input logic [2:0] k);
    logic [31:0] m;
    logic [4:0]  sh;
    m  = (k == 3'd0) ? 32'h55555555 :
         (k == 3'd1) ? 32'h33333333 :
         (k == 3'd2) ? 32'h0F0F0F0F :
         (k == 3'd3) ? 32'h00FF00FF : 32'h0000FFFF;
    sh = 5'd1 << k;
    return ((x & m) << sh) | ((x >> sh) & m);
  endfunction
`ifdef GREV_STAGE_SKIP_EN
  // index of the lowest set control bit at or above 'from'; 5 means none remain
  function automatic logic [2:0] next_set(input logic [4:0] c, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd5;
    for (int i = 4; i >= 0; i--)
      if (c[i] && i >= int'(from)) r = 3'(i);
    return r;
  endfunction
`endif
  // req1 wins when it is alone, or under round-robin when req0 had the last grant
  assign g1      = bus.req1_valid & (~bus.req0_valid | (FAIR_RR & ~last));
  assign bus.req0_ready = (state == IDLE) & ~reset & bus.req0_valid & ~g1;
  assign bus.req1_ready = (state == IDLE) & ~reset & g1;
  assign acc     = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);
  assign rs2_sel = g1 ? bus.req1_rs2 : bus.req0_rs2;
  assign stage_v = grev_stage(data, cnt);
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_rd    = (state == DONE) ? data : 32'h0;
  assign bus.rsp_id    = (state == DONE) & id;
  always_comb begin
    state_n = state;
    data_n  = data;
    ctl_n   = ctl;
    cnt_n   = cnt;
    id_n    = id;
    last_n  = last;
    if (state == IDLE && acc) begin
      data_n  = g1 ? bus.req1_rs1 : bus.req0_rs1;
      ctl_n   = rs2_sel;
      id_n    = g1;
      last_n  = g1;
`ifdef GREV_STAGE_SKIP_EN
      cnt_n   = next_set(rs2_sel, 3'd0);
      state_n = (rs2_sel == 5'd0) ? DONE : BUSY;
`else
      cnt_n   = 3'd0;
      state_n = BUSY;
`endif
    end else if (state == BUSY) begin
`ifdef GREV_STAGE_SKIP_EN
      data_n  = stage_v;
      cnt_n   = next_set(ctl, cnt + 3'd1);
      state_n = (cnt_n == 3'd5) ? DONE : BUSY;
`else
      data_n  = ctl[cnt] ? stage_v : data;
      cnt_n   = cnt + 3'd1;
      state_n = (cnt == 3'd4) ? DONE : BUSY;
`endif
    end else if (state == DONE && bus.rsp_ready) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      data  <= 32'h0;
      ctl   <= 5'd0;
      cnt   <= 3'd0;
      id    <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      data  <= data_n;
      ctl   <= ctl_n;
      cnt   <= cnt_n;
      id    <= id_n;
      last  <= last_n;
    end
  end
endmodule

// File: tb/tb_grev_arbiter.sv
// tb_grev_arbiter: directed vectors, corner sequences and a randomized reference-model run
module tb_grev_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  grev_arbiter_if bus0();
  grev_arbiter_if bus1();
  grev_arbiter #(.FAIR_RR(1'b1)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  grev_arbiter #(.FAIR_RR(1'b0)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  assign bus1.req0_valid = bus0.req0_valid;
  assign bus1.req1_valid = bus0.req1_valid;
  assign bus1.req0_rs1   = bus0.req0_rs1;
  assign bus1.req1_rs1   = bus0.req1_rs1;
  assign bus1.req0_rs2   = bus0.req0_rs2;
  assign bus1.req1_rs2   = bus0.req1_rs2;
  assign bus1.rsp_ready  = bus0.rsp_ready;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [4:0]  c0;
    logic [31:0] a1;
    logic [4:0]  c1;
    logic        eid;
    logic [31:0] erd;
  } vec_t;

  typedef struct {
    bit          busy;
    int          due;
    logic [31:0] res;
    bit          id;
    bit          last;
  } mdl_t;

  mdl_t m [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // each bit i of the operand lands at position i XOR rs2
  function automatic logic [31:0] grev_ref(input logic [31:0] x, input logic [4:0] c);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i ^ int'(c)] = x[i];
    return r;
  endfunction

  function automatic int lat(input logic [4:0] c);
`ifdef GREV_STAGE_SKIP_EN
    return 1 + $countones(c);
`else
    return (c === 5'dx) ? 0 : 6;
`endif
  endfunction

  task automatic drive(input logic v0, input logic v1, input logic [31:0] a0, input logic [4:0] c0,
                       input logic [31:0] a1, input logic [4:0] c1);
    bus0.req0_valid = v0;
    bus0.req1_valid = v1;
    bus0.req0_rs1   = a0;
    bus0.req0_rs2   = c0;
    bus0.req1_rs1   = a1;
    bus0.req1_rs2   = c1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'hDEADBEEF, 5'h1F, 32'hCAFEF00D, 5'h0F);
    bus0.rsp_ready = 1'b1;
    @(negedge clock);
    check("reset dut0 outputs", 64'({bus0.req0_ready, bus0.req1_ready, bus0.rsp_valid, bus0.rsp_id, bus0.rsp_rd}), 64'h0);
    check("reset dut1 outputs", 64'({bus1.req0_ready, bus1.req1_ready, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_rd}), 64'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 5'h0, 32'h0, 5'h0);
    bus0.rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int t0 = -1;
    int t1 = -1;
    logic gid = 1'b0;
    logic rid = 1'b0;
    logic [31:0] rd = 32'h0;
    @(posedge clock); #1;
    drive(v.v0, v.v1, v.a0, v.c0, v.a1, v.c1);
    bus0.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && t0 < 0; i++) begin
      @(negedge clock);
      if ((bus0.req0_valid && bus0.req0_ready) || (bus0.req1_valid && bus0.req1_ready)) begin
        t0  = cyc;
        gid = bus0.req1_ready;
      end
    end
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 32'h0, 5'h0, 32'h0, 5'h0);
    for (int i = 0; i < 20 && t0 >= 0 && t1 < 0; i++) begin
      @(negedge clock);
      if (bus0.rsp_valid) begin
        t1  = cyc;
        rd  = bus0.rsp_rd;
        rid = bus0.rsp_id;
      end
    end
    check($sformatf("vec%0d accepted", n), 64'(t0 >= 0), 64'd1);
    check($sformatf("vec%0d grant", n), 64'(gid), 64'(v.eid));
    check($sformatf("vec%0d latency", n), 64'(t1 - t0), 64'(lat(v.eid ? v.c1 : v.c0)));
    check($sformatf("vec%0d rsp_rd", n), 64'(rd), 64'(v.erd));
    check($sformatf("vec%0d rsp_id", n), 64'(rid), 64'(v.eid));
  endtask

  task automatic model_step(input int k, input bit fair, input logic r0, input logic r1, input logic rv,
                            input logic [31:0] rd, input logic rid);
    bit g1, e0, e1, ev;
    g1 = bus0.req1_valid && (!bus0.req0_valid || (fair && !m[k].last));
    e0 = !m[k].busy && bus0.req0_valid && !g1;
    e1 = !m[k].busy && g1;
    ev = m[k].busy && cyc >= m[k].due;
    check($sformatf("rnd dut%0d ready cyc %0d", k, cyc), 64'({r0, r1}), 64'({e0, e1}));
    check($sformatf("rnd dut%0d rsp cyc %0d", k, cyc), 64'({rv, rid, rd}),
          64'({ev, ev && m[k].id, ev ? m[k].res : 32'h0}));
    if (e0 || e1) begin
      m[k].busy = 1'b1;
      m[k].due  = cyc + lat(e1 ? bus0.req1_rs2 : bus0.req0_rs2);
      m[k].res  = e1 ? grev_ref(bus0.req1_rs1, bus0.req1_rs2) : grev_ref(bus0.req0_rs1, bus0.req0_rs2);
      m[k].id   = e1;
      m[k].last = e1;
    end else if (ev && bus0.rsp_ready) begin
      m[k].busy = 1'b0;
    end
  endtask

  initial begin
    vec_t vt [6];
    logic q0 [$];
    logic q1 [$];
    int   tq [$];
    int   t0;
    bit   seen;
    logic hid;
    drive(1'b0, 1'b0, 32'h0, 5'h0, 32'h0, 5'h0);
    bus0.rsp_ready = 1'b0;
    vt[0] = '{1'b1, 1'b0, 32'h12345678, 5'h1F, 32'h0,        5'h00, 1'b0, 32'h1E6A2C48};
    vt[1] = '{1'b0, 1'b1, 32'h0,        5'h00, 32'h12345678, 5'h18, 1'b1, 32'h78563412};
    vt[2] = '{1'b0, 1'b1, 32'h0,        5'h00, 32'h12345678, 5'h00, 1'b1, 32'h12345678};
    vt[3] = '{1'b1, 1'b1, 32'h00000001, 5'h11, 32'hFFFFFFFF, 5'h1F, 1'b0, 32'h00020000};
    vt[4] = '{1'b1, 1'b1, 32'h0,        5'h00, 32'h80000000, 5'h01, 1'b1, 32'h40000000};
    vt[5] = '{1'b1, 1'b1, 32'hAAAAAAAA, 5'h01, 32'h0,        5'h00, 1'b0, 32'h55555555};
    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // both requesters contend continuously: round-robin alternates, fixed priority sticks to req0
    do_reset();
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 32'h0F0F1234, 5'h1F, 32'hA5A5A5A5, 5'h1F);
    bus0.rsp_ready = 1'b1;
    for (int i = 0; i < 60 && (q0.size() < 4 || q1.size() < 4); i++) begin
      @(negedge clock);
      if (q0.size() < 4 && ((bus0.req0_valid && bus0.req0_ready) || (bus0.req1_valid && bus0.req1_ready))) begin
        q0.push_back(bus0.req1_ready);
        tq.push_back(cyc);
      end
      if (q1.size() < 4 && ((bus1.req0_valid && bus1.req0_ready) || (bus1.req1_valid && bus1.req1_ready)))
        q1.push_back(bus1.req1_ready);
    end
    check("rr grant count", 64'(q0.size()), 64'd4);
    check("fixed grant count", 64'(q1.size()), 64'd4);
    for (int i = 0; i < q0.size(); i++) check($sformatf("rr grant %0d", i), 64'(q0[i]), 64'(i % 2));
    for (int i = 0; i < q1.size(); i++) check($sformatf("fixed grant %0d", i), 64'(q1[i]), 64'd0);
    for (int i = 1; i < tq.size(); i++) check($sformatf("rr interval %0d", i), 64'(tq[i] - tq[i-1]), 64'd7);

    // response held under back-pressure, then released
    do_reset();
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 32'h12345678, 5'h1F, 32'h0, 5'h0);
    bus0.rsp_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = bus0.req0_valid && bus0.req0_ready;
    end
    check("hold accept", 64'(seen), 64'd1);
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 32'h11111111, 5'h03, 32'h22222222, 5'h05);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = bus0.rsp_valid;
    end
    check("hold rsp seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check($sformatf("hold cycle %0d", i),
            64'({bus0.rsp_valid, bus0.rsp_id, bus0.rsp_rd, bus0.req0_ready, bus0.req1_ready}),
            64'({1'b1, 1'b0, 32'h1E6A2C48, 1'b0, 1'b0}));
    end
    @(posedge clock); #1;
    bus0.rsp_ready = 1'b1;
    @(negedge clock);
    check("release cycle rsp_valid", 64'(bus0.rsp_valid), 64'd1);
    @(posedge clock); #1;
    bus0.rsp_ready = 1'b0;
    @(negedge clock);
    check("after release idle", 64'({bus0.rsp_valid, bus0.req0_ready, bus0.req1_ready}), 64'({1'b0, 1'b0, 1'b1}));

    // reset during BUSY stage 2 discards the operation; next contention goes to req0
    do_reset();
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 32'h12345678, 5'h1F, 32'h12345678, 5'h1F);
    bus0.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = bus0.req1_valid && bus0.req1_ready;
    end
    check("midreset accept", 64'(seen), 64'd1);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 32'h0, 5'h0, 32'h0, 5'h0);
    @(posedge clock);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("midreset immediate", 64'({bus0.rsp_valid, bus0.rsp_rd, bus0.req0_ready, bus0.req1_ready}), 64'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      seen = seen | bus0.rsp_valid;
    end
    check("midreset no response", 64'(seen), 64'd0);
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 32'h1, 5'h1, 32'h2, 5'h2);
    seen = 1'b0;
    hid  = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = (bus0.req0_valid && bus0.req0_ready) || (bus0.req1_valid && bus0.req1_ready);
      hid  = bus0.req1_ready;
    end
    check("post reset contention accept", 64'(seen), 64'd1);
    check("post reset contention grant", 64'(hid), 64'd0);

    // randomized traffic against the reference model for both arbitration modes
    do_reset();
    for (int k = 0; k < 2; k++) m[k] = '{1'b0, 0, 32'h0, 1'b0, 1'b1};
    repeat (2000) begin
      @(posedge clock); #1;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 5'($urandom),
            $urandom, 5'($urandom));
      bus0.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      model_step(0, 1'b1, bus0.req0_ready, bus0.req1_ready, bus0.rsp_valid, bus0.rsp_rd, bus0.rsp_id);
      model_step(1, 1'b0, bus1.req0_ready, bus1.req1_ready, bus1.rsp_valid, bus1.rsp_rd, bus1.rsp_id);
    end
    t0 = tests;
    if (t0 < 12) begin
      fails++;
      $display("FAIL test count: got %0d expected at least 12", t0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/grev_arbiter.md
GREV_ARBITER -- requirements
Module: grev_arbiter

Interface
REQ-001 SHALL have parameter FAIR_RR, default 1: 1 = round-robin grant between requesters, 0 = fixed priority (req0 always wins).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 SHALL have ports req0_rs1 / req1_rs1  input  32 each  data operand.
REQ-007 SHALL have ports req0_rs2 / req1_rs2  input  5 each  generalized-reverse control.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_rd  output  32  result value.
REQ-011 SHALL have port rsp_id  output  1  index of the requester that issued the operation.

Function
REQ-012 SHALL share one iterative generalized-reverse datapath between two requesters, with states IDLE, BUSY, DONE.
REQ-013 In IDLE, SHALL grant one valid requester; reqN_ready SHALL be combinational and high only in IDLE for the granted N. Accept = valid & ready.
REQ-014 On accept, SHALL capture rs1, rs2 and id, clear the stage counter to 0, and go to BUSY.
REQ-015 Arbitration: only one valid -> that one wins. Both valid with FAIR_RR=1 -> the requester not granted last. Both valid with FAIR_RR=0 -> req0.
REQ-016 last_grant SHALL update only on accept.
REQ-017 BUSY SHALL process one stage per cycle, k = 0..4. If rs2[k] = 1, it SHALL swap adjacent 2^k-bit fields of the working value using masks 55555555/33333333/0F0F0F0F/00FF00FF/0000FFFF (low field shifted up, high field shifted down). If rs2[k] = 0, the value SHALL be unchanged.
REQ-018 After stage 4, SHALL go to DONE. Accept in cycle T gives rsp_valid high in cycle T+6.
REQ-019 In DONE, rsp_valid SHALL be 1, with rsp_rd and rsp_id held stable until rsp_valid & rsp_ready. On that cycle SHALL return to IDLE.
REQ-020 No new accept SHALL occur in BUSY or DONE. Back-to-back throughput SHALL be one operation per 7 cycles when rsp_ready is held at 1.
REQ-021 Requester inputs SHALL be ignored outside the accept cycle.
REQ-022 rsp_rd and rsp_id SHALL be 0 whenever rsp_valid = 0.

Reset
REQ-023 On reset assertion, SHALL immediately enter IDLE with rsp_valid = 0, rsp_rd = 0, rsp_id = 0, both ready = 0, counter = 0, last_grant = 1 (req0 wins first contention).
REQ-024 Reset mid-operation SHALL discard the in-flight operation with no response.
REQ-025 On the first cycle after deassertion, arbitration SHALL resume normally.

Configuration
REQ-026 Macro GREV_STAGE_SKIP_EN. When defined, BUSY SHALL visit only stages with rs2[k] = 1, in ascending order, one per cycle. Response latency SHALL be T+1+popcount(rs2). If rs2 = 0, SHALL go IDLE->DONE directly (rsp_valid at T+1).
REQ-027 When GREV_STAGE_SKIP_EN is undefined, the fixed five-stage timing of REQ-018 SHALL apply.

Verification
REQ-028 req0: rs1=0x12345678, rs2=0x1F, accept at T -> rsp_valid at T+6, rsp_rd=0x1E6A2C48, rsp_id=0.
REQ-029 req1: rs1=0x12345678, rs2=0x18 -> rsp_rd=0x78563412, rsp_id=1. rs2=0x00 -> rsp_rd=0x12345678 (with GREV_STAGE_SKIP_EN: at T+1).
REQ-030 Both valid continuously, FAIR_RR=1, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0. FAIR_RR=0 -> always 0.
REQ-031 rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_rd and rsp_id stable. Both ready=0 throughout. Return to IDLE on the cycle rsp_ready=1.
REQ-032 Assert reset during BUSY (stage 2) -> rsp_valid=0 immediately and no response emitted. Next contention grants req0.
REQ-033 GREV_STAGE_SKIP_EN, rs2=0x11, rs1=0x00000001 -> rsp_valid at T+3, rsp_rd=0x00020000.
